// File: rtl/iiitb_seq_det_param.sv
// -----------------------------------------------------------------------------
// iiitb_seq_det_param
//
// Purpose
//   Run-time programmable Moore sequence detector.
//   - The pattern is 1..MAX_LEN bits long.
//   - Pattern, length and overlap mode are loaded through cfg_*.
//   - dout is a registered single-cycle pulse for each match.
//   - Matches are counted in a saturating counter.
//
// Optional feature
//   Define SEQ_DET_STICKY_EN to add a sticky match flag:
//     sticky_clr (in)  clears the flag
//     sticky     (out) set by any match, held until cleared or reset
//
// Ports
//   clk          in   1        clock
//   reset        in   1        synchronous, active-high
//   din          in   1        serial data bit
//   din_valid    in   1        din is sampled only when this is 1
//   cfg_we       in   1        load cfg_* on this edge (din on that cycle is dropped)
//   cfg_pattern  in   MAX_LEN  pattern; bit[len-1] is received first, bit[0] last
//   cfg_len      in   LEN_W    pattern length; 0 disables, >MAX_LEN clamps to MAX_LEN
//   cfg_overlap  in   1        1: matches may share bits; 0: history flushed after a match
//   dout         out  1        one-cycle match pulse
//   match_count  out  CNT_W    matches since reset/config, saturating
//   busy         out  1        1 while the FSM is in FILL or ARMED
//
// Handshake
//   din is consumed on every rising clk edge where din_valid=1, the detector is
//   enabled (len!=0) and cfg_we=0. There is no back-pressure; the detector is
//   always ready.
// -----------------------------------------------------------------------------
module iiitb_seq_det_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy
`ifdef SEQ_DET_STICKY_EN
  ,
  input  logic               sticky_clr,
  output logic               sticky
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t             state;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [LEN_W-1:0]   len_clamped;
  logic [MAX_LEN-1:0] len_mask;
  logic               accept;
  logic               match;

  always_comb begin
    len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

    // A config write takes priority over data arriving on the same edge.
    accept    = din_valid && (state != IDLE) && !cfg_we;
    hist_next = {hist[MAX_LEN-2:0], din};

    // fill only needs to reach len; it never grows past it.
    fill_next = (fill >= len_q) ? len_q : fill + 1'b1;

    // Only the low len bits of history and pattern take part in the compare.
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end

    match = accept && (fill_next >= len_q) &&
            ((hist_next & len_mask) == (pattern_q & len_mask));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pattern_q   <= '0;
      len_q       <= '0;
      overlap_q   <= 1'b1;
      hist        <= '0;
      fill        <= '0;
      dout        <= 1'b0;
      match_count <= '0;
      busy        <= 1'b0;
    end else if (cfg_we) begin
      pattern_q   <= cfg_pattern;
      len_q       <= len_clamped;
      overlap_q   <= cfg_overlap;
      hist        <= '0;
      fill        <= '0;
      dout        <= 1'b0;
      match_count <= '0;
      if (len_clamped != '0) begin
        state <= FILL;
        busy  <= 1'b1;
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end else begin
      dout <= 1'b0;
      if (accept) begin
        if (match) begin
          dout <= 1'b1;
          if (match_count != '1) begin
            match_count <= match_count + 1'b1;
          end
          if (overlap_q) begin
            hist  <= hist_next;
            fill  <= fill_next;
            state <= ARMED;
          end else begin
            // Non-overlapping: the next match needs len brand-new bits.
            hist  <= '0;
            fill  <= '0;
            state <= FILL;
          end
        end else begin
          hist  <= hist_next;
          fill  <= fill_next;
          state <= (fill_next == len_q) ? ARMED : FILL;
        end
      end
    end
  end

`ifdef SEQ_DET_STICKY_EN
  // A match on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky <= 1'b0;
    end else if (match) begin
      sticky <= 1'b1;
    end else if (sticky_clr) begin
      sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_iiitb_seq_det_param.sv
module tb_iiitb_seq_det_param;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       din;
  logic       din_valid;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       sticky_clr;
  logic       dout, dout2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  logic       busy, busy2;
  logic       sticky, sticky2;

  always #5 clk = ~clk;

  iiitb_seq_det_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .dout(dout), .match_count(match_count),
    .busy(busy)
`ifdef SEQ_DET_STICKY_EN
    , .sticky_clr(sticky_clr), .sticky(sticky)
`endif
  );

  // Narrow counter copy to exercise saturation.
  iiitb_seq_det_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .dout(dout2), .match_count(match_count2),
    .busy(busy2)
`ifdef SEQ_DET_STICKY_EN
    , .sticky_clr(sticky_clr), .sticky(sticky2)
`endif
  );

`ifndef SEQ_DET_STICKY_EN
  assign sticky  = 1'b0;
  assign sticky2 = 1'b0;
`endif

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Keeps the bits received since the last flush as a list and compares the
  // newest len of them against the pattern, first-received bit first.
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_q[$];
  int         m_cnt;
  bit         m_dout;
  bit         m_sticky;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_edge(input logic r, input logic v, input logic d, input logic we,
                            input logic [7:0] p, input logic [3:0] l, input logic o,
                            input logic sc);
    bit hit;
    if (r) begin
      m_pat = '0; m_len = 0; m_ovl = 1'b1; m_q.delete();
      m_cnt = 0; m_dout = 1'b0; m_sticky = 1'b0;
    end else if (we) begin
      m_pat = p; m_len = (int'(l) > 8) ? 8 : int'(l); m_ovl = o;
      m_q.delete(); m_cnt = 0; m_dout = 1'b0;
      if (sc) m_sticky = 1'b0;
    end else begin
      hit = 1'b0;
      if (v && m_len != 0) begin
        m_q.push_back(d);
        if (m_q.size() > m_len) void'(m_q.pop_front());
        if (m_q.size() == m_len) begin
          hit = 1'b1;
          for (int i = 0; i < m_len; i++)
            if (m_q[i] != m_pat[m_len-1-i]) hit = 1'b0;
        end
      end
      m_dout = hit;
      if (hit) begin
        m_cnt++;
        if (!m_ovl) m_q.delete();
        m_sticky = 1'b1;
      end else if (sc) begin
        m_sticky = 1'b0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic v, input logic d, input logic we,
                      input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic sc);
    reset = r; din_valid = v; din = d; cfg_we = we;
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; sticky_clr = sc;
    @(posedge clk);
    model_edge(r, v, d, we, p, l, o, sc);
    #1;
    check("dout", dout, m_dout);
    check("match_count", match_count, sat(m_cnt, 8));
    check("busy", busy, (m_len != 0));
    check("dout_w2", dout2, m_dout);
    check("match_count_w2", match_count2, sat(m_cnt, 2));
`ifdef SEQ_DET_STICKY_EN
    check("sticky", sticky, m_sticky);
    check("sticky_w2", sticky2, m_sticky);
`endif
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 8'h00, 4'd0, 1, 0);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    step(0, 0, 0, 1, p, l, o, 0);
  endtask

  task automatic bit_in(input logic d);
    step(0, 1, d, 0, 8'h00, 4'd0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00, 4'd0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] seq7;
  logic [7:0] rp;
  logic [3:0] rl;

  initial begin
    reset = 1'b1; din = 0; din_valid = 0; cfg_we = 0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; sticky_clr = 0;

    do_reset(2);
    check("reset_count", match_count, 0);
    check("reset_busy", busy, 0);

    // 1001001, overlapping: pulses after bits 4 and 7.
    seq7 = 7'b1001001;
    cfg(8'b0000_1001, 4'd4, 1);
    for (int i = 6; i >= 0; i--) begin
      bit_in(seq7[i]);
      if (i == 3 || i == 0) check("ovl_pulse", dout, 1);
    end
    check("ovl_total", match_count, 2);

    // Same stream, non-overlapping: only the first match.
    cfg(8'b0000_1001, 4'd4, 0);
    for (int i = 6; i >= 0; i--) bit_in(seq7[i]);
    check("novl_total", match_count, 1);

    // 1001 with 3 idle cycles between bits.
    cfg(8'b0000_1001, 4'd4, 1);
    for (int i = 3; i >= 0; i--) begin
      bit_in(seq7[i + 3]);
      if (i == 0) check("gap_pulse", dout, 1);
      if (i != 0) begin
        idle(3);
        check("gap_low", dout, 0);
      end
    end
    idle(1);
    check("gap_total", match_count, 1);

    // Reconfigure mid-pattern with din_valid high; new 8-bit all-ones pattern.
    bit_in(1); bit_in(0); bit_in(0);
    step(0, 1, 1, 1, 8'hFF, 4'd8, 1, 0);
    check("cfg_clr_count", match_count, 0);
    check("cfg_clr_dout", dout, 0);
    for (int i = 0; i < 8; i++) bit_in(1);
    check("len8_pulse", dout, 1);
    check("len8_total", match_count, 1);

    // len=1, six ones: narrow counter saturates at 3.
    cfg(8'h01, 4'd1, 0);
    for (int i = 0; i < 6; i++) begin
      bit_in(1);
      check("len1_pulse", dout2, 1);
      check("len1_sat", match_count2, (i < 3) ? i + 1 : 3);
    end

    // Reset after three bits of 1001, reconfigure, one more "1": no match.
    cfg(8'b0000_1001, 4'd4, 1);
    bit_in(1); bit_in(0); bit_in(0);
    do_reset(1);
    cfg(8'b0000_1001, 4'd4, 1);
    bit_in(1);
    check("reset_mid_nopulse", dout, 0);

    // Clamped length (12 -> 8) and disabled detector (len 0).
    cfg(8'hA5, 4'd12, 1);
    for (int i = 7; i >= 0; i--) bit_in(rp_bit(8'hA5, i));
    check("clamp_pulse", dout, 1);
    cfg(8'h01, 4'd0, 1);
    for (int i = 0; i < 4; i++) bit_in(1);
    check("len0_busy", busy, 0);
    check("len0_count", match_count, 0);

`ifdef SEQ_DET_STICKY_EN
    // sticky rises with the first pulse, holds, and wins over a coincident clear.
    do_reset(1);
    cfg(8'h01, 4'd2, 1);
    bit_in(0); bit_in(1);
    check("sticky_set", sticky, 1);
    idle(3);
    check("sticky_hold", sticky, 1);
    bit_in(0);
    step(0, 1, 1, 0, 8'h00, 4'd0, 0, 1);
    check("sticky_set_wins", sticky, 1);
    step(0, 0, 0, 0, 8'h00, 4'd0, 0, 1);
    check("sticky_cleared", sticky, 0);
`endif

    // Randomized traffic.
    do_reset(1);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             8'($urandom), 4'($urandom), $urandom_range(0, 1), 0);
      end else if (n == 0 || $urandom_range(0, 59) == 0) begin
        rp = 8'($urandom);
        rl = 4'($urandom_range(0, 10));
        step(0, $urandom_range(0, 1), $urandom_range(0, 1), 1, rp, rl,
             $urandom_range(0, 1), $urandom_range(0, 7) == 0);
      end else begin
        step(0, $urandom_range(0, 9) < 7, $urandom_range(0, 1), 0,
             8'($urandom), 4'($urandom), $urandom_range(0, 1),
             $urandom_range(0, 7) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  function automatic logic rp_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
